// File: rtl/dac_wave_ctrl.sv
// Periodic waveform sequencer for the I2C DAC driver: one start/data request per
// update tick, with DC, sawtooth, triangle and square sample generation.
module dac_wave_ctrl #(
    parameter int unsigned SYS_CLK  = 50_000_000,
    parameter int unsigned TICK_DIV = 50_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       wave_en,
    input  logic [1:0] wave_sel,
    input  logic [7:0] step,
    input  logic [7:0] level,
    input  logic       dac_done,
    input  logic       clr_ovr,
    output logic       dac_start,
    output logic [7:0] dac_data,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REQ, S_BUSY} state_t;
    typedef enum logic [1:0] {W_DC, W_SAW, W_TRI, W_SQR} wave_t;

    localparam logic [23:0] CNT_MAX = 24'(TICK_DIV - 1);

    if (TICK_DIV < 2 || TICK_DIV > 32'h00FF_FFFF || SYS_CLK == 0) begin : g_bad_param
        $error("dac_wave_ctrl: TICK_DIV must be 2..2^24-1 and SYS_CLK nonzero");
    end

    state_t      r_state;
    wave_t       r_sel;
    logic [23:0] r_cnt;
    logic [7:0]  r_step;
    logic [7:0]  r_level;
    logic [7:0]  r_sample;
    logic        r_dir_up;
    logic [7:0]  r_phase;
    logic        r_sq_hi;
    logic        r_start;
    logic [7:0]  r_data;
    logic        r_busy;
    logic        r_ovr;

    logic        w_tick;
    logic [8:0]  w_sum;
    logic [7:0]  w_ph_inc;
    logic [7:0]  w_nxt_sample;
    logic        w_nxt_dir;
    logic [7:0]  w_nxt_phase;
    logic        w_nxt_hi;

    assign w_tick   = (r_state != S_IDLE) && (r_cnt == CNT_MAX);
    assign w_sum    = {1'b0, r_sample} + {1'b0, r_step};
    assign w_ph_inc = r_phase + 8'd1;

    always_comb begin
        w_nxt_sample = r_sample;
        w_nxt_dir    = r_dir_up;
        w_nxt_phase  = r_phase;
        w_nxt_hi     = r_sq_hi;
        case (r_sel)
            W_DC:  w_nxt_sample = r_level;
            W_SAW: w_nxt_sample = w_sum[7:0];
            W_TRI: begin
                if (r_dir_up) begin
                    if (w_sum[8]) begin
                        w_nxt_sample = 8'hFF;
                        w_nxt_dir    = 1'b0;
                    end else begin
                        w_nxt_sample = w_sum[7:0];
                    end
                end else if (r_sample < r_step) begin
                    w_nxt_sample = '0;
                    w_nxt_dir    = 1'b1;
                end else begin
                    w_nxt_sample = r_sample - r_step;
                end
            end
            W_SQR: begin
                // Phase counts samples already emitted at the current level.
                if (w_ph_inc == r_step) begin
                    w_nxt_hi     = ~r_sq_hi;
                    w_nxt_phase  = '0;
                    w_nxt_sample = r_sq_hi ? 8'h00 : r_level;
                end else begin
                    w_nxt_phase  = w_ph_inc;
                    w_nxt_sample = r_sq_hi ? r_level : 8'h00;
                end
            end
            default: w_nxt_sample = r_sample;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state  <= S_IDLE;
            r_sel    <= W_DC;
            r_cnt    <= '0;
            r_step   <= 8'd1;
            r_level  <= '0;
            r_sample <= '0;
            r_dir_up <= 1'b1;
            r_phase  <= '0;
            r_sq_hi  <= 1'b1;
            r_start  <= 1'b0;
            r_data   <= '0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_start <= 1'b0;
            // Set is evaluated after clear so a colliding overrun tick wins.
            if (clr_ovr) r_ovr <= 1'b0;
            if (w_tick && (r_state == S_REQ || r_state == S_BUSY)) r_ovr <= 1'b1;

            if (r_state == S_IDLE) r_cnt <= '0;
            else if (w_tick)       r_cnt <= '0;
            else                   r_cnt <= r_cnt + 24'd1;

            case (r_state)
                S_IDLE: begin
                    if (wave_en) begin
                        r_sel    <= wave_t'(wave_sel);
                        r_step   <= (step == 8'd0) ? 8'd1 : step;
                        r_level  <= level;
                        r_sample <= (wave_sel == W_DC || wave_sel == W_SQR) ? level : 8'h00;
                        r_dir_up <= 1'b1;
                        r_phase  <= '0;
                        r_sq_hi  <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!wave_en) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        r_start <= 1'b1;
                        r_data  <= r_sample;
                        r_busy  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: r_state <= S_BUSY;
                S_BUSY: begin
                    if (dac_done) begin
                        r_sample <= w_nxt_sample;
                        r_dir_up <= w_nxt_dir;
                        r_phase  <= w_nxt_phase;
                        r_sq_hi  <= w_nxt_hi;
                        r_busy   <= 1'b0;
                        r_state  <= wave_en ? S_RUN : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dac_start = r_start;
    assign dac_data  = r_data;
    assign busy      = r_busy;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_dac_wave_ctrl.sv
// Bench for dac_wave_ctrl: a delayed-completion driver model, a start monitor and a
// transaction-level reference for sample values, request timing and overrun.
module tb_dac_wave_ctrl;

    localparam int TD = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wave_en;
    logic [1:0] wave_sel;
    logic [7:0] step;
    logic [7:0] level;
    logic       dac_done;
    logic       clr_ovr;
    logic       dac_start;
    logic [7:0] dac_data;
    logic       busy;
    logic       overrun;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         lat = 4;
    int         busy_cnt = 0;
    int         q_cyc[$];
    logic [7:0] q_dat[$];

    dac_wave_ctrl #(.SYS_CLK(50_000_000), .TICK_DIV(TD)) u_dut (
        .sys_clk  (clk),
        .sys_rst  (rst_n),
        .wave_en  (wave_en),
        .wave_sel (wave_sel),
        .step     (step),
        .level    (level),
        .dac_done (dac_done),
        .clr_ovr  (clr_ovr),
        .dac_start(dac_start),
        .dac_data (dac_data),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dac_start) begin
            q_cyc.push_back(cyc);
            q_dat.push_back(dac_data);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    // Driver model: completion pulse visible 'lat' cycles after the request cycle.
    initial begin
        dac_done = 1'b0;
        forever begin
            @(negedge clk);
            if (dac_start) begin
                repeat (lat) @(posedge clk);
                #1 dac_done = 1'b1;
                @(posedge clk);
                #1 dac_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        wave_en = 1'b0;
        repeat (40) @(posedge clk);
        #1 clr_ovr = 1'b1;
        @(posedge clk);
        #1 clr_ovr = 1'b0;
        q_cyc.delete();
        q_dat.delete();
        @(negedge clk);
        busy_cnt = 0;
    endtask

    task automatic run_wave(input logic [1:0] sel, input logic [7:0] stp, input logic [7:0] lvl,
                            input int n, input int dly);
        int         en_cyc, t0, t, s, st, ph, budget;
        bit         up, hi, exp_ovr;
        int         exp_cyc[$];
        logic [7:0] exp_dat[$];
        go_idle();
        lat = dly;
        @(posedge clk);
        #1;
        wave_sel = sel; step = stp; level = lvl; wave_en = 1'b1;
        en_cyc = cyc;
        @(posedge clk);
        #1;
        wave_sel = 2'($urandom); step = 8'($urandom); level = 8'($urandom);

        st = (stp == 0) ? 1 : int'(stp);
        s  = (sel == 2'd0 || sel == 2'd3) ? int'(lvl) : 0;
        up = 1; hi = 1; ph = 0;
        for (int i = 0; i < n; i++) begin
            exp_dat.push_back(8'(s));
            case (sel)
                2'd0: s = lvl;
                2'd1: s = (s + st) % 256;
                2'd2: begin
                    if (up) begin
                        if (s + st > 255) begin s = 255; up = 0; end
                        else s = s + st;
                    end else if (s < st) begin
                        s = 0; up = 1;
                    end else s = s - st;
                end
                default: begin
                    ph++;
                    if (ph == st) begin hi = !hi; ph = 0; end
                    s = hi ? int'(lvl) : 0;
                end
            endcase
        end
        t0 = en_cyc + TD;
        exp_cyc.push_back(en_cyc + TD + 1);
        for (int i = 1; i < n; i++) begin
            t = t0;
            while (t < exp_cyc[i-1] + dly + 1) t += TD;
            exp_cyc.push_back(t + 1);
        end
        exp_ovr = 0;
        for (int i = 0; i < n; i++)
            for (int k = t0; k <= exp_cyc[i] + dly; k += TD)
                if (k >= exp_cyc[i]) exp_ovr = 1;

        budget = n * 30 + 60;
        while (q_cyc.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #1 wave_en = 1'b0;
        check("start_timeout", 32'(q_cyc.size() >= n), 32'd1);
        for (int i = 0; i < n && i < q_cyc.size(); i++) begin
            check($sformatf("data[%0d] sel%0d", i, sel), 32'(q_dat[i]), 32'(exp_dat[i]));
            check($sformatf("cycle[%0d] sel%0d", i, sel), 32'(q_cyc[i] - en_cyc), 32'(exp_cyc[i] - en_cyc));
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("no_extra_start", 32'(q_cyc.size()), 32'(n));
        check("busy_cycles", 32'(busy_cnt), 32'(n * (dly + 1)));
        check("busy_after_stop", 32'(busy), 32'd0);
        check("overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    initial begin
        int c;
        rst_n = 1'b0; wave_en = 1'b0; wave_sel = '0; step = '0; level = '0; clr_ovr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start", 32'(dac_start), 32'd0);
        check("rst_data", 32'(dac_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        #1 rst_n = 1'b1;

        run_wave(2'd0, 8'h11, 8'h80, 5, 4);
        run_wave(2'd1, 8'h60, 8'h33, 5, 4);
        run_wave(2'd2, 8'h70, 8'h44, 8, 4);
        run_wave(2'd3, 8'd2,  8'hAA, 5, 4);
        run_wave(2'd3, 8'd0,  8'hAA, 6, 4);
        for (int r = 0; r < 6; r++)
            run_wave(2'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                     8'($urandom), 6, $urandom_range(1, 15));
        run_wave(2'd0, 8'd1, 8'h5A, 3, 15);

        // Overrun clear versus a colliding tick, then reset mid-transfer.
        go_idle();
        lat = 15;
        @(posedge clk);
        #1 wave_sel = 2'd0; level = 8'h3C; step = 8'd1; wave_en = 1'b1;
        c = 0;
        while (q_cyc.size() < 1 && c < 60) begin @(posedge clk); c++; end
        check("ovr_first_start", 32'(q_cyc.size()), 32'd1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("ovr_set", 32'(overrun), 32'd1);
        repeat (2) @(posedge clk);
        #1 clr_ovr = 1'b1;
        @(posedge clk);
        #1 clr_ovr = 1'b0;
        @(negedge clk);
        check("ovr_clear", 32'(overrun), 32'd0);
        repeat (16) @(posedge clk);
        #1 clr_ovr = 1'b1;
        @(posedge clk);
        #1 clr_ovr = 1'b0;
        @(negedge clk);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        check("ovr_starts", 32'(q_cyc.size()), 32'd2);
        if (q_cyc.size() >= 2) check("ovr_period", 32'(q_cyc[1] - q_cyc[0]), 32'd20);

        c = 0;
        while (q_cyc.size() < 3 && c < 60) begin @(posedge clk); c++; end
        check("rst_mid_start", 32'(q_cyc.size()), 32'd3);
        #1 rst_n = 1'b0; wave_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_start", 32'(dac_start), 32'd0);
        check("midrst_data", 32'(dac_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ovr", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("late_done_busy", 32'(busy), 32'd0);
        check("late_done_starts", 32'(q_cyc.size()), 32'd3);
        check("late_done_ovr", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
